// File: rtl/imm_field_packer_if.sv
// Handshake and data bundle for imm_field_packer: upstream word/immediate in,
// packed instruction plus error flags out.
interface imm_field_packer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_range_err;
  logic             out_fmt_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_instr, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_range_err, out_fmt_err, err_count
  );

  modport slave (
    input  in_valid, in_instr, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_range_err, out_fmt_err, err_count
  );
endinterface

// File: rtl/imm_field_packer.sv
// Inserts a truncated signed immediate into the format-specific field of an
// instruction word, flagging misfit immediates; 2-stage valid/ready pipeline.
module imm_field_packer #(
  parameter bit STRICT = 1'b0,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  imm_field_packer_if.slave bus
);
  typedef enum logic [1:0] {
    FMT_B   = 2'b00,
    FMT_BAD = 2'b01,
    FMT_CB  = 2'b10,
    FMT_D   = 2'b11
  } fmt_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fmt_e        in_fmt;
  logic        in_fit;
  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [25:0] s1_imm;
  fmt_e        s1_fmt;
  logic        s1_fit;
  logic        s1_load;
  logic        s2_load;
  logic        clear_field;
  logic [31:0] pk_instr;
  logic        pk_range;
  logic        pk_fmt;
  logic             out_valid_q;
  logic [31:0]      out_instr_q;
  logic             out_range_q;
  logic             out_fmt_q;
  logic [CNT_W-1:0] err_count_q;

  assign s2_load      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;

  assign in_fmt = fmt_e'(bus.in_instr[31:30]);

  // The immediate fits an N-bit field when every bit from N-1 upward matches.
  always_comb begin
    in_fit = 1'b1;
    case (in_fmt)
      FMT_D:   in_fit = (&bus.in_imm[63:8])  || !(|bus.in_imm[63:8]);
      FMT_CB:  in_fit = (&bus.in_imm[63:18]) || !(|bus.in_imm[63:18]);
      FMT_B:   in_fit = (&bus.in_imm[63:25]) || !(|bus.in_imm[63:25]);
      default: in_fit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_imm   <= '0;
      s1_fmt   <= FMT_B;
      s1_fit   <= 1'b1;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s1_load) begin
        s1_instr <= bus.in_instr;
        s1_imm   <= bus.in_imm[25:0];
        s1_fmt   <= in_fmt;
        s1_fit   <= in_fit;
      end
    end
  end

  assign clear_field = STRICT && !s1_fit;

  always_comb begin
    pk_instr = s1_instr;
    pk_range = 1'b0;
    pk_fmt   = 1'b0;
    case (s1_fmt)
      FMT_D: begin
        pk_range        = !s1_fit;
        pk_instr[20:12] = clear_field ? 9'd0 : s1_imm[8:0];
      end
      FMT_CB: begin
        pk_range       = !s1_fit;
        pk_instr[23:5] = clear_field ? 19'd0 : s1_imm[18:0];
      end
      FMT_B: begin
        pk_range       = !s1_fit;
        pk_instr[25:0] = clear_field ? 26'd0 : s1_imm[25:0];
      end
      default: pk_fmt = 1'b1;
    endcase
  end

  // Output data only changes when the stage is free, so a stalled word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_range_q <= 1'b0;
      out_fmt_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_instr_q <= pk_instr;
        out_range_q <= pk_range;
        out_fmt_q   <= pk_fmt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (out_valid_q && bus.out_ready && (out_range_q || out_fmt_q)
                 && (err_count_q != CNT_MAX)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_instr     = out_instr_q;
  assign bus.out_range_err = out_range_q;
  assign bus.out_fmt_err   = out_fmt_q;
  assign bus.err_count     = err_count_q;
endmodule
